// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional performance counters in inst_fetch_q are enabled by defining FETCH_PERF_CNT_EN.
package fetch_pkg;

   // Bytes per instruction word; sequential fetch advances the PC by this much.
   localparam int INSTR_BYTES = 4;

   // Canonical no-op encoding (addi x0, x0, 0) for downstream bubble insertion.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_INSTR_W = 32;

   // Queue entry for the default 32/32 build; the top passes a width-matched
   // struct of the same layout when ADDR_W/INSTR_W are overridden.
   typedef struct packed {
      logic [DEF_ADDR_W-1:0]  pc;
      logic [DEF_INSTR_W-1:0] instr;
   } fetch_entry_t;

   // Saturating 32-bit accumulate used by the performance counters.
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] inc);
      logic [32:0] sum;
      sum = {1'b0, cnt} + {1'b0, inc};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries: push, pop and clear (clear beats push).
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   clear_i,
   input  entry_t                 wdata_i,
   output entry_t                 rdata_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o,
   output logic                   full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Next pointer/count: clear wins, otherwise push and pop act independently.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage write port.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; occupancy tracking alone decides which entries are meaningful.
      if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/inst_fetch_q.sv
// Fetch stage: PC, imem read issue, redirect handling and a prefetch queue to decode.
// Define FETCH_PERF_CNT_EN to add perf_fetched / perf_dropped / perf_stall counters.
module inst_fetch_q
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                INSTR_W  = 32,
   parameter int                IMEM_AW  = 11,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_en,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               flush,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic               imem_rden,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic [ADDR_W-1:0]  pc_plus_four
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_dropped,
   output logic [31:0]        perf_stall
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc;
      logic [INSTR_W-1:0] instr;
   } entry_t;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic              pend_q, pend_d;
   logic              issue, push, pop;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_empty, fifo_full;
   entry_t            push_entry, head;

   // Credit uses the registered count plus the in-flight read, so a response
   // always has a free slot even if decode does not pop that cycle.
   // Gating with rst keeps the read request low while reset is held.
   assign issue = rst & fetch_en & ~redirect_valid & ~fifo_full
                & ((fifo_count + CNT_W'(pend_q)) < CNT_W'(DEPTH));
   assign push  = pend_q & ~redirect_valid;
   assign pop   = instr_valid & instr_ready;

   assign flush        = redirect_valid;
   assign imem_rden    = issue;
   assign imem_addr    = pc_q[IMEM_AW-1:0];
   assign instr_valid  = ~fifo_empty & ~redirect_valid;
   assign instr        = head.instr;
   assign instr_pc     = head.pc;
   assign pc_plus_four = head.pc + ADDR_W'(INSTR_BYTES);

   assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

   // PC / request bookkeeping: redirect overrides issue and drops the in-flight read.
   always_comb begin
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      pend_d   = 1'b0;
      if (redirect_valid) begin
         pc_d = redirect_pc & ~ADDR_W'(3);
      end else if (issue) begin
         pc_d     = pc_q + ADDR_W'(INSTR_BYTES);
         req_pc_d = pc_q;
         pend_d   = 1'b1;
      end
   end

   // PC and outstanding-read registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         pend_q   <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         pend_q   <= pend_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .clear_i (redirect_valid),
      .wdata_i (push_entry),
      .rdata_o (head),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetched_q, fetched_d;
   logic [31:0] dropped_q, dropped_d;
   logic [31:0] stall_q, stall_d;

   // Counter updates; a redirect drops the in-flight response plus every queued entry.
   always_comb begin
      fetched_d = sat_inc(fetched_q, 32'(push));
      dropped_d = redirect_valid ? sat_inc(dropped_q, 32'(fifo_count) + 32'(pend_q)) : dropped_q;
      stall_d   = sat_inc(stall_q, 32'(instr_valid & ~instr_ready));
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetched_q <= '0;
         dropped_q <= '0;
         stall_q   <= '0;
      end else begin
         fetched_q <= fetched_d;
         dropped_q <= dropped_d;
         stall_q   <= stall_d;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_dropped = dropped_q;
   assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch_q.sv
// Self-checking bench for inst_fetch_q against a queue-based behavioural model.
module tb_inst_fetch_q;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic [10:0] imem_addr;
   logic        imem_rden;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc_plus_four;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_dropped, perf_stall;
`endif

   int errors = 0;
   int checks = 0;

   inst_fetch_q dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .imem_addr      (imem_addr),
      .imem_rden      (imem_rden),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .pc_plus_four   (pc_plus_four)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_dropped   (perf_dropped),
      .perf_stall     (perf_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [10:0] a);
      return {21'b0, a} ^ 32'hA5A5_A5A5;
   endfunction

   // Synchronous-read instruction memory, one cycle of latency.
   always @(posedge clk) if (imem_rden === 1'b1) imem_rdata <= mem_word(imem_addr);

   // ---------------- behavioural reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   typedef struct packed {
      logic        flush;
      logic        rden;
      logic [10:0] addr;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] ppf;
   } obs_t;

   ent_t        m_q[$];
   logic [31:0] m_pc, m_req_pc;
   bit          m_pend;
   logic [31:0] m_fetched, m_dropped, m_stall;
   bit          cur_rv, cur_rdy, exp_issue;
   logic [31:0] cur_rpc;
   obs_t        exp_obs;

   task automatic model_reset();
      m_q.delete();
      m_pc      = 32'h0;
      m_req_pc  = 32'h0;
      m_pend    = 0;
      m_fetched = 0;
      m_dropped = 0;
      m_stall   = 0;
   endtask

   function automatic obs_t observe();
      obs_t o;
      o       = '0;
      o.flush = flush;
      o.rden  = imem_rden;
      if (imem_rden !== 1'b0) o.addr = imem_addr;
      o.valid = instr_valid;
      if (instr_valid !== 1'b0) begin
         o.instr = instr;
         o.pc    = instr_pc;
         o.ppf   = pc_plus_four;
      end
      return o;
   endfunction

   // Apply one cycle of inputs (at posedge+2) and compute what the outputs must be.
   task automatic drive(input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
      int cnt;
      fetch_en       = fe;
      redirect_valid = rv;
      redirect_pc    = rpc;
      instr_ready    = rdy;
      cur_rv  = rv;
      cur_rpc = rpc;
      cur_rdy = rdy;
      #1;
      cnt       = m_q.size();
      exp_issue = fe && !rv && (cnt + int'(m_pend) < DEPTH);
      exp_obs       = '0;
      exp_obs.flush = rv;
      exp_obs.rden  = exp_issue;
      if (exp_issue) exp_obs.addr = m_pc[10:0];
      exp_obs.valid = (cnt > 0) && !rv;
      if (exp_obs.valid) begin
         exp_obs.instr = m_q[0].instr;
         exp_obs.pc    = m_q[0].pc;
         exp_obs.ppf   = m_q[0].pc + 32'd4;
      end
   endtask

   // Advance the model across the clock edge, then move to posedge+2.
   task automatic advance();
      int cnt;
      cnt = m_q.size();
      if (cnt > 0 && !cur_rv && !cur_rdy) m_stall++;
      if (cur_rv) begin
         m_dropped += 32'(cnt) + 32'(m_pend);
         m_q.delete();
      end else begin
         if (cnt > 0 && cur_rdy) void'(m_q.pop_front());
         if (m_pend) begin
            m_q.push_back('{m_req_pc, mem_word(m_req_pc[10:0])});
            m_fetched++;
         end
      end
      if (cur_rv) begin
         m_pc   = cur_rpc & ~32'h3;
         m_pend = 0;
      end else if (exp_issue) begin
         m_req_pc = m_pc;
         m_pc     = m_pc + 32'd4;
         m_pend   = 1;
      end else begin
         m_pend = 0;
      end
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      fetch_en       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
      #1;
      if (imem_rden !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b expected 0", imem_rden); end
      checks++;
      if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
      checks++;
`ifdef FETCH_PERF_CNT_EN
      if ({perf_fetched, perf_dropped, perf_stall} !== 96'h0) begin
         errors++; $display("FAIL reset_perf: got %h expected 0", {perf_fetched, perf_dropped, perf_stall});
      end
      checks++;
`endif
      do_reset();
   endtask

   task automatic test_stream();
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 0, 1);
         if (observe() !== exp_obs) begin errors++; $display("FAIL stream c%0d: got %h expected %h", i, observe(), exp_obs); end
         checks++;
         if (i == 0 && !(imem_rden === 1'b1 && imem_addr === 11'h000)) begin
            errors++; $display("FAIL stream_first_issue: got rden=%b addr=%h expected 1/000", imem_rden, imem_addr);
         end
         if (i == 0) checks++;
         advance();
      end
   endtask

   task automatic test_backpressure();
      logic [10:0] first_addr;
      bit          seen;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 0, 0);
         if (observe() !== exp_obs) begin errors++; $display("FAIL bp_stall c%0d: got %h expected %h", i, observe(), exp_obs); end
         checks++;
         if (i == 9 && !(imem_rden === 1'b0 && instr_valid === 1'b1 && instr_pc === 32'h0)) begin
            errors++; $display("FAIL bp_full: got rden=%b valid=%b pc=%h expected 0/1/0", imem_rden, instr_valid, instr_pc);
         end
         if (i == 9) checks++;
         advance();
      end
      seen = 0;
      first_addr = '0;
      for (int i = 0; i < 12; i++) begin
         drive(1, 0, 0, 1);
         if (observe() !== exp_obs) begin errors++; $display("FAIL bp_drain c%0d: got %h expected %h", i, observe(), exp_obs); end
         checks++;
         if (!seen && imem_rden === 1'b1) begin seen = 1; first_addr = imem_addr; end
         advance();
      end
      if (!(seen && first_addr === 11'h010)) begin
         errors++; $display("FAIL bp_resume: got seen=%b addr=%h expected 1/010", seen, first_addr);
      end
      checks++;
   endtask

   task automatic test_redirect();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0);
         if (observe() !== exp_obs) begin errors++; $display("FAIL redir_fill c%0d: got %h expected %h", i, observe(), exp_obs); end
         checks++;
         advance();
      end
      drive(1, 1, 32'h200, 1);
      if (observe() !== exp_obs) begin errors++; $display("FAIL redir_cycle: got %h expected %h", observe(), exp_obs); end
      checks++;
      if (!(flush === 1'b1 && instr_valid === 1'b0)) begin
         errors++; $display("FAIL redir_flush: got flush=%b valid=%b expected 1/0", flush, instr_valid);
      end
      checks++;
      advance();
      drive(1, 0, 0, 1);
      if (!(instr_valid === 1'b0 && imem_rden === 1'b1 && imem_addr === 11'h200)) begin
         errors++; $display("FAIL redir_target: got valid=%b rden=%b addr=%h expected 0/1/200", instr_valid, imem_rden, imem_addr);
      end
      checks++;
`ifdef FETCH_PERF_CNT_EN
      if (perf_dropped !== 32'd4) begin errors++; $display("FAIL redir_dropped: got %0d expected 4", perf_dropped); end
      checks++;
`endif
      for (int i = 0; i < 6; i++) begin
         if (observe() !== exp_obs) begin errors++; $display("FAIL redir_after c%0d: got %h expected %h", i, observe(), exp_obs); end
         checks++;
         advance();
         drive(1, 0, 0, 1);
      end
      advance();
   endtask

   task automatic test_misaligned();
      drive(1, 1, 32'h103, 1);
      advance();
      drive(1, 0, 0, 1);
      if (!(imem_rden === 1'b1 && imem_addr === 11'h100)) begin
         errors++; $display("FAIL misaligned: got rden=%b addr=%h expected 1/100", imem_rden, imem_addr);
      end
      checks++;
      advance();
   endtask

   task automatic test_back_to_back();
      bit saw40;
      drive(1, 1, 32'h40, 1);
      advance();
      drive(1, 1, 32'h80, 1);
      advance();
      saw40 = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, 0, 1);
         if (observe() !== exp_obs) begin errors++; $display("FAIL b2b c%0d: got %h expected %h", i, observe(), exp_obs); end
         checks++;
         if ((instr_valid === 1'b1 && instr_pc === 32'h40) || (imem_rden === 1'b1 && imem_addr === 11'h040)) saw40 = 1;
         advance();
      end
      if (saw40) begin errors++; $display("FAIL b2b_stale: got 0x40 presented expected never"); end
      checks++;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 1);
         advance();
      end
      drive(1, 0, 0, 1);
      #1;
      rst = 1'b0;
      #1;
      if (!(imem_rden === 1'b0 && instr_valid === 1'b0)) begin
         errors++; $display("FAIL midrst_outputs: got rden=%b valid=%b expected 0/0", imem_rden, instr_valid);
      end
      checks++;
`ifdef FETCH_PERF_CNT_EN
      if ({perf_fetched, perf_dropped, perf_stall} !== 96'h0) begin
         errors++; $display("FAIL midrst_perf: got %h expected 0", {perf_fetched, perf_dropped, perf_stall});
      end
      checks++;
`endif
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      drive(1, 0, 0, 1);
      if (!(imem_rden === 1'b1 && imem_addr === 11'h000)) begin
         errors++; $display("FAIL midrst_restart: got rden=%b addr=%h expected 1/000", imem_rden, imem_addr);
      end
      checks++;
      for (int i = 0; i < 5; i++) begin
         if (observe() !== exp_obs) begin errors++; $display("FAIL midrst_after c%0d: got %h expected %h", i, observe(), exp_obs); end
         checks++;
         advance();
         drive(1, 0, 0, 1);
      end
      advance();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 2) != 0);
         if (observe() !== exp_obs) begin errors++; $display("FAIL random c%0d: got %h expected %h", i, observe(), exp_obs); end
         checks++;
         advance();
      end
`ifdef FETCH_PERF_CNT_EN
      if ({perf_fetched, perf_dropped, perf_stall} !== {m_fetched, m_dropped, m_stall}) begin
         errors++; $display("FAIL random_perf: got %h expected %h", {perf_fetched, perf_dropped, perf_stall}, {m_fetched, m_dropped, m_stall});
      end
      checks++;
`endif
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_misaligned();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
